bnn_serial_classifier: RTL
==========================

# bnn_serial_classifier

Parametrised binary-neural-network output layer for the MNIST BNN tile: bit-serial weight load, bit-serial pixel stream, parallel XNOR-popcount per class, then a sequential argmax. It generalises the fixed single-digit engine behind the top-level pins (mode, pixel_in, weight_in, 4-bit answer). It adds configurable input and class counts, an input-valid qualifier, reloadable weights, a winning-score output and a done pulse. It sits directly under the tt_um_mnist_bnn wrapper, which maps ui_in/uo_out onto these ports.

## Interface
- N_IN, 64: binary inputs (pixels) per frame.
- N_CLASS, 10: output classes.
- CLS_W, 4: answer width, ≥ ceil(log2(N_CLASS)).
- CNT_W, 7: score/accumulator width, = ceil(log2(N_IN+1)).

- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  global enable; 0 freezes every register.
- mode  in  1  0 = weight load, 1 = inference.
- in_valid  in  1  qualifies weight_in/pixel_in this cycle.
- weight_in  in  1  serial weight bit (1 = +1, 0 = −1).
- pixel_in  in  1  serial pixel bit.
- answer  out  CLS_W  winning class index, registered.
- score  out  CNT_W  winning popcount, registered.
- done  out  1  one-cycle pulse when answer/score update.
- busy  out  1  high in INFER (pidx≠0) and ARGMAX.
- weights_loaded  out  1  full weight set present.

## Operation
- Weight store: N_CLASS×N_IN bits, class-major. Serial index widx = c·N_IN + i, range 0..N_CLASS·N_IN−1.
- LOAD (mode=0, in_valid=1, not ARGMAX):
  - Write weight_in to w[widx] and increment widx.
  - Accepting a bit at widx=0 clears weights_loaded.
  - Accepting the bit at widx = N_CLASS·N_IN−1 sets weights_loaded and wraps widx to 0.
- INFER (mode=1, in_valid=1, weights_loaded=1, not ARGMAX):
  - For every class c in parallel, acc[c] += XNOR(pixel_in, w[c][pidx]). pidx increments.
  - Accepting the first pixel (pidx=0) also zeroes all acc before adding.
  - Accepting the pixel at pidx = N_IN−1 wraps pidx to 0 and enters ARGMAX.
- Pixels presented while weights_loaded=0 are dropped; no state changes.
- ARGMAX:
  - Scans c = 0..N_CLASS−1, one class per cycle, holding running best (idx, val).
  - Replace best only on strict greater-than, so ties resolve to the lowest index.
  - After the last class, answer/score load from best and done pulses.
  - in_valid is ignored throughout ARGMAX.
- States: IDLE → (first pixel) INFER → (N_IN-th pixel) ARGMAX → (N_CLASS cycles) IDLE with done. LOAD is not a separate state; widx advances from IDLE only.
- Abort: mode changing while pidx≠0 zeroes pidx and returns to IDLE. The partial frame is discarded, answer/score are unchanged and there is no done. mode changing while 0<widx leaves widx as is, so a load resumes where it stopped.
- Arithmetic: acc is unsigned CNT_W bits, maximum N_IN, no overflow possible. score = number of matching bits, equivalent to (N_IN + dot product)/2.

## Timing
- Reset values: answer=0, score=0, done=0, busy=0, weights_loaded=0, weights=0, acc=0, widx=0, pidx=0, state IDLE.
- Reset is asynchronous, so assertion mid-ARGMAX or mid-load clears everything immediately.
- Latency: last pixel captured at edge E. ARGMAX compares on edges E+1..E+N_CLASS. answer/score update and done rises at edge E+N_CLASS, and done falls at E+N_CLASS+1. Default is 10 cycles.
- busy rises on the edge capturing the first pixel and falls with done.
- Back-to-back frames: the next frame's first pixel is accepted on the edge at which done rises or any later edge.
- ena=0 holds all registers, including done, ARGMAX progress and counters. in_valid is ignored while ena=0.

## Test plan
- Reset: drive rst_n=0 mid-stream, then release → all outputs at reset values; first pixel with weights_loaded=0 is ignored (busy stays 0).
- Single winner: load weights with class 3 all ones and others all zeros; stream 64 pixels of 1 → done 10 cycles after the last pixel, answer=3, score=64.
- Tie: all weights 0, 64 pixels of 0 → answer=0, score=64. Then class 7 weights = alternating 1/0 and pixels all 1 → answer=7, score=32.
- Gapped valid: the single-winner frame with in_valid low on random cycles → identical answer/score; done count 1.
- Abort and reload: send 30 pixels, toggle mode to 0 → busy falls, no done. Then a full reload clears weights_loaded at the first bit and sets it after 640 bits.
- ena freeze: drop ena for 5 cycles during ARGMAX → done is delayed by exactly 5 cycles and the result is unchanged.

Source files
------------

// File: rtl/bnn_serial_classifier.sv
// bnn_serial_classifier: BNN output layer. Weights and pixels arrive one bit
// per cycle; every class lane does XNOR-popcount in parallel, then a
// sequential argmax picks the winner (ties go to the lowest class index).

// One class: its weight row plus its running match count.
module bnn_class_lane #(
  parameter int N_IN   = 64,
  parameter int CNT_W  = 7,
  parameter int PIDX_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              w_we,
  input  logic [PIDX_W-1:0] w_idx,
  input  logic              w_bit,
  input  logic              px_en,
  input  logic              px_first,
  input  logic [PIDX_W-1:0] px_idx,
  input  logic              px_bit,
  output logic [CNT_W-1:0]  acc
);
  logic [N_IN-1:0]  w_q, w_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             match;

  // Weight write and accumulate; the first pixel of a frame restarts the count
  always_comb begin
    w_d   = w_q;
    acc_d = acc_q;
    match = ~(px_bit ^ w_q[px_idx]);
    if (w_we) w_d[w_idx] = w_bit;
    if (px_en) acc_d = (px_first ? '0 : acc_q) + {{(CNT_W-1){1'b0}}, match};
  end

  // Lane state register, frozen while ena is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q   <= '0;
      acc_q <= '0;
    end else if (ena) begin
      w_q   <= w_d;
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;
endmodule

module bnn_serial_classifier #(
  parameter int N_IN    = 64,
  parameter int N_CLASS = 10,
  parameter int CLS_W   = 4,
  parameter int CNT_W   = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             mode,
  input  logic             in_valid,
  input  logic             weight_in,
  input  logic             pixel_in,
  output logic [CLS_W-1:0] answer,
  output logic [CNT_W-1:0] score,
  output logic             done,
  output logic             busy,
  output logic             weights_loaded
);
  localparam int PIDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_INFER, S_ARGMAX} state_t;

  state_t                          state_q, state_d;
  logic [PIDX_W-1:0]               pidx_q, pidx_d;
  logic [CLS_W-1:0]                wcls_q, wcls_d;   // widx split as class/bit
  logic [PIDX_W-1:0]               wbit_q, wbit_d;
  logic                            loaded_q, loaded_d;
  logic [CLS_W-1:0]                cidx_q, cidx_d;
  logic [CLS_W-1:0]                best_idx_q, best_idx_d;
  logic [CNT_W-1:0]                best_val_q, best_val_d;
  logic [CLS_W-1:0]                answer_q, answer_d;
  logic [CNT_W-1:0]                score_q, score_d;
  logic                            done_q, done_d;

  logic [N_CLASS-1:0][CNT_W-1:0]   acc;
  logic [N_CLASS-1:0]              lane_we;
  logic                            px_en, px_first, ld_en, take;
  logic [CNT_W-1:0]                cur_val;

  genvar g;
  generate
    for (g = 0; g < N_CLASS; g++) begin : g_lane
      bnn_class_lane #(.N_IN(N_IN), .CNT_W(CNT_W), .PIDX_W(PIDX_W)) u_lane (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .w_we     (lane_we[g]),
        .w_idx    (wbit_q),
        .w_bit    (weight_in),
        .px_en    (px_en),
        .px_first (px_first),
        .px_idx   (pidx_q),
        .px_bit   (pixel_in),
        .acc      (acc[g])
      );
    end
  endgenerate

  // Route a loaded weight bit to the class row selected by the load pointer
  always_comb begin
    lane_we = '0;
    for (int c = 0; c < N_CLASS; c++)
      lane_we[c] = ld_en && (wcls_q == CLS_W'(c));
  end

  // Next-state: frame sequencing, argmax scan, weight-load pointer
  always_comb begin
    state_d    = state_q;
    pidx_d     = pidx_q;
    wcls_d     = wcls_q;
    wbit_d     = wbit_q;
    loaded_d   = loaded_q;
    cidx_d     = cidx_q;
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    answer_d   = answer_q;
    score_d    = score_q;
    done_d     = 1'b0;
    px_en      = 1'b0;
    px_first   = 1'b0;
    ld_en      = 1'b0;
    cur_val    = acc[cidx_q];
    // class 0 seeds the running best; later classes need strictly more
    take       = (cidx_q == '0) || (cur_val > best_val_q);

    case (state_q)
      S_IDLE: begin
        if (mode && in_valid && loaded_q) begin
          px_en    = 1'b1;
          px_first = 1'b1;
        end else if (!mode && in_valid) begin
          ld_en = 1'b1;
        end
      end
      S_INFER: begin
        // leaving inference mode mid-frame throws the partial frame away
        if (!mode) begin
          state_d = S_IDLE;
          pidx_d  = '0;
        end else if (in_valid) begin
          px_en = 1'b1;
        end
      end
      S_ARGMAX: begin
        best_idx_d = take ? cidx_q  : best_idx_q;
        best_val_d = take ? cur_val : best_val_q;
        if (cidx_q == CLS_W'(N_CLASS-1)) begin
          cidx_d   = '0;
          state_d  = S_IDLE;
          answer_d = best_idx_d;
          score_d  = best_val_d;
          done_d   = 1'b1;
          // the next frame may start on the same edge that publishes this one;
          // the last class's acc is read here before the lanes clear it
          if (mode && in_valid && loaded_q) begin
            px_en    = 1'b1;
            px_first = 1'b1;
          end
        end else begin
          cidx_d = cidx_q + CLS_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (px_en) begin
      if (pidx_q == PIDX_W'(N_IN-1)) begin
        pidx_d  = '0;
        state_d = S_ARGMAX;
      end else begin
        pidx_d  = pidx_q + PIDX_W'(1);
        state_d = S_INFER;
      end
    end

    if (ld_en) begin
      if (wcls_q == '0 && wbit_q == '0) loaded_d = 1'b0;
      if (wbit_q == PIDX_W'(N_IN-1)) begin
        wbit_d = '0;
        if (wcls_q == CLS_W'(N_CLASS-1)) begin
          wcls_d   = '0;
          loaded_d = 1'b1;
        end else begin
          wcls_d = wcls_q + CLS_W'(1);
        end
      end else begin
        wbit_d = wbit_q + PIDX_W'(1);
      end
    end
  end

  // Control/result registers, frozen while ena is low (done included)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pidx_q     <= '0;
      wcls_q     <= '0;
      wbit_q     <= '0;
      loaded_q   <= 1'b0;
      cidx_q     <= '0;
      best_idx_q <= '0;
      best_val_q <= '0;
      answer_q   <= '0;
      score_q    <= '0;
      done_q     <= 1'b0;
    end else if (ena) begin
      state_q    <= state_d;
      pidx_q     <= pidx_d;
      wcls_q     <= wcls_d;
      wbit_q     <= wbit_d;
      loaded_q   <= loaded_d;
      cidx_q     <= cidx_d;
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
      answer_q   <= answer_d;
      score_q    <= score_d;
      done_q     <= done_d;
    end
  end

  assign answer         = answer_q;
  assign score          = score_q;
  assign done           = done_q;
  assign busy           = (state_q != S_IDLE);
  assign weights_loaded = loaded_q;
endmodule
